// File: rtl/regfile_gen.sv
// regfile_gen -- parametrised general-purpose register file for the MIPS
// R/I/J datapath, with two write ports and a sequenced clear engine.
//
// Parameters
//   DATA_W   : register width in bits
//   ADDR_W   : address width; DEPTH = 2**ADDR_W registers
//   ZERO_REG : 1 -> register 0 is hardwired to zero (writes discarded)
//
// Ports
//   clkb              : clock; all state updates on the falling edge
//   rstb              : asynchronous active-high reset (clears every register)
//   we_a/w_addr_a/w_data_a : write port A
//   we_b/w_addr_b/w_data_b : write port B (wins over A on the same address)
//   r_addr_a/r_data_a : combinational read port A
//   r_addr_b/r_data_b : combinational read port B
//   clr_req           : start a one-register-per-cycle clear sweep
//   clr_busy          : high while sweeping and during the done cycle
//   clr_done          : one-cycle pulse after the last register is cleared
//
// Optional feature (macro REGFILE_GEN_BYPASS_EN): when defined, an enabled,
// unblocked write to the address being read is forwarded to that read port
// in the same cycle (port B over port A; address 0 still reads 0 with
// ZERO_REG = 1). When undefined, reads return array contents only.
module regfile_gen #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int ZERO_REG = 1
) (
  input  logic              clkb,
  input  logic              rstb,
  input  logic              we_a,
  input  logic [ADDR_W-1:0] w_addr_a,
  input  logic [DATA_W-1:0] w_data_a,
  input  logic              we_b,
  input  logic [ADDR_W-1:0] w_addr_b,
  input  logic [DATA_W-1:0] w_data_b,
  input  logic [ADDR_W-1:0] r_addr_a,
  input  logic [ADDR_W-1:0] r_addr_b,
  output logic [DATA_W-1:0] r_data_a,
  output logic [DATA_W-1:0] r_data_b,
  input  logic              clr_req,
  output logic              clr_busy,
  output logic              clr_done
);

  localparam int DEPTH = 2 ** ADDR_W;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CLEAR = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  state_t            state_reg, state_next;
  logic [ADDR_W-1:0] cnt_reg, cnt_next;
  logic              sweep_en;
  logic              write_open;

  logic [DATA_W-1:0] regs [DEPTH];

  // ---------------------------------------------------------------------
  // Clear FSM: state register
  // ---------------------------------------------------------------------
  always_ff @(negedge clkb or posedge rstb) begin
    if (rstb) begin
      state_reg <= ST_IDLE;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  // ---------------------------------------------------------------------
  // Clear FSM: next-state logic
  // ---------------------------------------------------------------------
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    case (state_reg)
      ST_IDLE: begin
        if (clr_req) begin
          state_next = ST_CLEAR;
          cnt_next   = '0;
        end
      end
      ST_CLEAR: begin
        // Leave on the last address and park the counter at 0 so the
        // increment never wraps into a second sweep.
        if (&cnt_reg) begin
          state_next = ST_DONE;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      ST_DONE: begin
        // clr_req is not sampled here: a held request restarts from IDLE.
        state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
        cnt_next   = '0;
      end
    endcase
  end

  // ---------------------------------------------------------------------
  // Clear FSM: outputs
  // ---------------------------------------------------------------------
  always_comb begin
    clr_busy   = (state_reg == ST_CLEAR) || (state_reg == ST_DONE);
    clr_done   = (state_reg == ST_DONE);
    sweep_en   = (state_reg == ST_CLEAR);
    write_open = !clr_busy;
  end

  // ---------------------------------------------------------------------
  // Register storage: one flop group per entry. Priority per entry is
  // sweep clear, then port B, then port A.
  // ---------------------------------------------------------------------
  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_reg
      if (ZERO_REG != 0 && gi == 0) begin : g_zero
        assign regs[gi] = '0;
      end else begin : g_store
        logic [DATA_W-1:0] q_reg, q_next;

        always_comb begin
          q_next = q_reg;
          if (sweep_en) begin
            if (cnt_reg == ADDR_W'(gi)) q_next = '0;
          end else if (write_open) begin
            if (we_a && (w_addr_a == ADDR_W'(gi))) q_next = w_data_a;
            if (we_b && (w_addr_b == ADDR_W'(gi))) q_next = w_data_b;
          end
        end

        always_ff @(negedge clkb or posedge rstb) begin
          if (rstb) q_reg <= '0;
          else      q_reg <= q_next;
        end

        assign regs[gi] = q_reg;
      end
    end
  endgenerate

  // ---------------------------------------------------------------------
  // Read ports (combinational). Both ports share one description.
  // ---------------------------------------------------------------------
  logic [ADDR_W-1:0] rd_addr [2];
  logic [DATA_W-1:0] rd_data [2];

  assign rd_addr[0] = r_addr_a;
  assign rd_addr[1] = r_addr_b;
  assign r_data_a   = rd_data[0];
  assign r_data_b   = rd_data[1];

  generate
    for (gi = 0; gi < 2; gi++) begin : g_rd
      always_comb begin
        rd_data[gi] = regs[rd_addr[gi]];
`ifdef REGFILE_GEN_BYPASS_EN
        // Forward only writes that will actually land this cycle.
        if (write_open) begin
          if (we_a && (w_addr_a == rd_addr[gi])) rd_data[gi] = w_data_a;
          if (we_b && (w_addr_b == rd_addr[gi])) rd_data[gi] = w_data_b;
        end
`endif
        // Hardwired zero overrides any forwarded value.
        if (ZERO_REG != 0 && rd_addr[gi] == '0) rd_data[gi] = '0;
      end
    end
  endgenerate

endmodule

// File: tb/tb_regfile_gen.sv
// tb_regfile_gen -- randomized self-checking bench for regfile_gen
// (default parameters: 32 x 32, ZERO_REG = 1).
module tb_regfile_gen;

  localparam int DEPTH = 32;

  logic        clkb;
  logic        rstb;
  logic        we_a, we_b, clr_req;
  logic [4:0]  w_addr_a, w_addr_b, r_addr_a, r_addr_b;
  logic [31:0] w_data_a, w_data_b;
  logic [31:0] r_data_a, r_data_b;
  logic        clr_busy, clr_done;

  int total = 0;
  int bad   = 0;

  // Reference model: plain array plus sweep bookkeeping.
  logic [31:0] model [DEPTH];
  int          clr_left;   // registers still to be swept (0 = no sweep)
  bit          done_pend;  // the cycle after the last sweep write

  regfile_gen dut (
    .clkb     (clkb),
    .rstb     (rstb),
    .we_a     (we_a),
    .w_addr_a (w_addr_a),
    .w_data_a (w_data_a),
    .we_b     (we_b),
    .w_addr_b (w_addr_b),
    .w_data_b (w_data_b),
    .r_addr_a (r_addr_a),
    .r_addr_b (r_addr_b),
    .r_data_a (r_data_a),
    .r_data_b (r_data_b),
    .clr_req  (clr_req),
    .clr_busy (clr_busy),
    .clr_done (clr_done)
  );

  initial clkb = 1'b0;
  always #5 clkb = ~clkb;

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic bit model_busy();
    return (clr_left > 0) || done_pend;
  endfunction

  function automatic logic [31:0] exp_read(input logic [4:0] a);
    logic [31:0] v;
    v = model[a];
`ifdef REGFILE_GEN_BYPASS_EN
    if (!model_busy()) begin
      if (we_a && w_addr_a == a) v = w_data_a;
      if (we_b && w_addr_b == a) v = w_data_b;
    end
`endif
    if (a == 5'd0) v = 32'h0;
    return v;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) model[i] = 32'h0;
    clr_left  = 0;
    done_pend = 1'b0;
  endtask

  // Effect of one falling edge on the model.
  task automatic model_edge();
    if (clr_left > 0) begin
      model[DEPTH - clr_left] = 32'h0;
      clr_left--;
      if (clr_left == 0) done_pend = 1'b1;
    end else if (done_pend) begin
      done_pend = 1'b0;
    end else begin
      if (we_a && w_addr_a != 5'd0) model[w_addr_a] = w_data_a;
      if (we_b && w_addr_b != 5'd0) model[w_addr_b] = w_data_b;
      if (clr_req) clr_left = DEPTH;
    end
  endtask

  task automatic set_idle();
    we_a = 1'b0; we_b = 1'b0; clr_req = 1'b0;
  endtask

  // Called in the high phase with inputs already driven: check the
  // pre-edge outputs, take the falling edge, return at posedge+1.
  task automatic cycle(input string tag);
    #1;
    $display("tx %s wa=%0b@%0d wb=%0b@%0d clr=%0b ra=%0d rb=%0d busy=%0b done=%0b",
             tag, we_a, w_addr_a, we_b, w_addr_b, clr_req, r_addr_a, r_addr_b,
             clr_busy, clr_done);
    check_val({tag, ":rd_a"}, r_data_a, exp_read(r_addr_a));
    check_val({tag, ":rd_b"}, r_data_b, exp_read(r_addr_b));
    check_val({tag, ":busy"}, 32'(clr_busy), 32'(model_busy()));
    check_val({tag, ":done"}, 32'(clr_done), 32'(done_pend));
    @(negedge clkb);
    model_edge();
    @(posedge clkb);
    #1;
  endtask

  int busy_cnt, done_cnt;

  initial begin
    rstb = 1'b1;
    set_idle();
    w_addr_a = 0; w_addr_b = 0; w_data_a = 0; w_data_b = 0;
    r_addr_a = 0; r_addr_b = 0;
    model_reset();
    repeat (2) @(posedge clkb);
    #1 rstb = 1'b0;

    // Reset state: every register reads zero, no clear activity.
    for (int i = 0; i < DEPTH; i++) begin
      r_addr_a = 5'(i);
      r_addr_b = 5'(DEPTH - 1 - i);
      #1;
      check_val("rst_rd_a", r_data_a, 32'h0);
      check_val("rst_rd_b", r_data_b, 32'h0);
    end
    check_val("rst_busy", 32'(clr_busy), 32'h0);
    check_val("rst_done", 32'(clr_done), 32'h0);

    // Basic write then read.
    we_a = 1; w_addr_a = 5; w_data_a = 32'hDEADBEEF; r_addr_a = 5;
    cycle("wr5");
    set_idle();
    #1 check_val("rd5", r_data_a, 32'hDEADBEEF);

    // Writes to register 0 are discarded.
    we_a = 1; w_addr_a = 0; w_data_a = 32'h12345678; r_addr_a = 0;
    cycle("wr0");
    set_idle();
    #1 check_val("rd0", r_data_a, 32'h0);

    // Same-address collision: port B wins.
    we_a = 1; w_addr_a = 7; w_data_a = 32'h1111;
    we_b = 1; w_addr_b = 7; w_data_b = 32'h2222;
    cycle("coll7");
    set_idle();
    r_addr_b = 7;
    #1 check_val("rd7", r_data_b, 32'h2222);

    // Bypass / no-bypass behaviour before the edge.
    we_a = 1; w_addr_a = 4; w_data_a = 32'h1234;
    cycle("wr4");
    set_idle();
    we_b = 1; w_addr_b = 4; w_data_b = 32'hCAFE; r_addr_b = 4;
    #1;
`ifdef REGFILE_GEN_BYPASS_EN
    check_val("byp4_pre", r_data_b, 32'hCAFE);
`else
    check_val("byp4_pre", r_data_b, 32'h1234);
`endif
    cycle("byp4");
    set_idle();
    #1 check_val("byp4_post", r_data_b, 32'hCAFE);

    // Load 1..31 with their index, then sweep.
    for (int i = 1; i < DEPTH; i++) begin
      we_a = 1; w_addr_a = 5'(i); w_data_a = 32'(i); r_addr_a = 5'(i);
      cycle("load");
    end
    set_idle();
    clr_req = 1;
    cycle("clr_req");
    clr_req = 0;
    busy_cnt = 0;
    done_cnt = 0;
    for (int k = 0; k < 40; k++) begin
      set_idle();
      r_addr_a = 5'($urandom_range(0, 31));
      r_addr_b = 5'($urandom_range(0, 31));
      if (k == 10) begin
        r_addr_a = 9; r_addr_b = 20;
        we_a = 1; w_addr_a = 3; w_data_a = 32'hAAAA;
        clr_req = 1;  // ignored while busy
        #1;
        check_val("mid_rd9", r_data_a, 32'h0);
        check_val("mid_rd20", r_data_b, 32'd20);
      end
      if (clr_busy && !clr_done) busy_cnt++;
      if (clr_done) done_cnt++;
      cycle("sweep");
    end
    set_idle();
    check_val("sweep_busy_cycles", 32'(busy_cnt), 32'd32);
    check_val("sweep_done_pulses", 32'(done_cnt), 32'd1);
    for (int i = 0; i < DEPTH; i++) begin
      r_addr_a = 5'(i);
      #1 check_val("post_clr_rd", r_data_a, 32'h0);
    end

    // Reset in the middle of a sweep.
    we_a = 1; w_addr_a = 30; w_data_a = 32'h55;
    cycle("wr30");
    set_idle();
    clr_req = 1;
    cycle("clr_req2");
    set_idle();
    for (int k = 0; k < 15; k++) cycle("sweep2");
    r_addr_a = 30;
    #1 check_val("pre_rst_rd30", r_data_a, 32'h55);
    rstb = 1'b1;
    model_reset();
    #1;
    check_val("rst_rd30", r_data_a, 32'h0);
    check_val("rst_busy2", 32'(clr_busy), 32'h0);
    check_val("rst_done2", 32'(clr_done), 32'h0);
    rstb = 1'b0;
    done_cnt = 0;
    for (int k = 0; k < 40; k++) begin
      if (clr_done) done_cnt++;
      cycle("after_rst");
    end
    check_val("rst_no_done", 32'(done_cnt), 32'd0);

    // Randomized traffic against the model.
    for (int n = 0; n < 400; n++) begin
      we_a     = 1'($urandom_range(0, 1));
      we_b     = 1'($urandom_range(0, 1));
      w_addr_a = 5'($urandom_range(0, 31));
      w_addr_b = ($urandom_range(0, 3) == 0) ? w_addr_a : 5'($urandom_range(0, 31));
      w_data_a = $urandom;
      w_data_b = $urandom;
      r_addr_a = ($urandom_range(0, 2) == 0) ? w_addr_a : 5'($urandom_range(0, 31));
      r_addr_b = ($urandom_range(0, 2) == 0) ? w_addr_b : 5'($urandom_range(0, 31));
      clr_req  = ($urandom_range(0, 59) == 0);
      cycle("rnd");
    end
    set_idle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
